rf_commit_sched: RTL and testbench
==================================

Name: rf_commit_sched

Overview:
- Commit-side scheduler for the architectural register file.
- Accepts retired results (rd, value, ROB tag) from the ROB through a valid/ready handshake and buffers them in a small FIFO.
- Drains the FIFO onto the RF write port at one write per cycle, holding off during flush cycles, when the RF ignores writes.
- Provides decode-time forwarding of buffered values that are not yet written, so the RF is never read stale.

Parameters:
REG_NUM_WIDTH, 5, register index width (32 regs).
ROB_SIZE_WIDTH, 3, ROB index width; tags are ROB_SIZE_WIDTH+1 bits, all-ones = "no dependency".
DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
clk_in  in  1  clock.
rst_in  in  1  reset; synchronous, active-low.
rdy_in  in  1  global ready; low = full stall.
need_flush_in  in  1  pipeline flush.
cm_valid  in  1  ROB commit request.
cm_ready  out  1  scheduler can accept.
cm_rd  in  REG_NUM_WIDTH  destination register.
cm_value  in  32  result.
cm_tag  in  ROB_SIZE_WIDTH+1  ROB entry of the commit.
rf_valid  out  1  RF write strobe.
rf_rd  out  REG_NUM_WIDTH  RF write index.
rf_value  out  32  RF write data.
rf_tag  out  ROB_SIZE_WIDTH+1  tag compared by the RF to clear a dependency.
fwd_rs1  in  REG_NUM_WIDTH  decode source 1.
fwd_rs2  in  REG_NUM_WIDTH  decode source 2.
fwd_hit1  out  1  rs1 has a buffered value.
fwd_val1  out  32  that value.
fwd_hit2  out  1  rs2 has a buffered value.
fwd_val2  out  32  that value.
empty_out  out  1  FIFO empty.

Behaviour:
- Reset (rst_in==0 at posedge):
  - head, tail and count = 0; all stale bits cleared.
  - While rst_in is low: cm_ready=0, rf_valid=0, fwd_hit*=0, empty_out=1.
- rdy_in low: no state change; cm_ready=0, rf_valid=0; forwarding outputs stay valid (combinational).
- Enqueue:
  - Occurs when cm_valid && cm_ready at a posedge.
  - cm_ready = rst_in && rdy_in && (count<DEPTH), computed combinationally from count.
  - There is no same-cycle pass-through, so a full FIFO stays non-ready even if a pop happens in that cycle.
  - cm_rd==0 is accepted but not stored (count unchanged).
- Issue:
  - rf_valid = rdy_in && !empty && !need_flush_in; rf_* show the head entry combinationally.
  - The head pops at the same posedge rf_valid is high.
  - Enqueue-to-RF latency is 1 cycle minimum.
  - Simultaneous push and pop leaves count unchanged.
- Flush:
  - In a cycle with need_flush_in=1, no issue occurs; entries stay buffered because they are architecturally retired.
  - Every stored entry, and any entry enqueued in that same cycle, gets stale=1.
  - Stale entries drive rf_tag = all-ones, because the RF has already cleared its dependencies and must not re-clear or match them.
  - Issue resumes the next cycle.
- Forwarding:
  - fwd_hitN=1 if any valid entry has rd==fwd_rsN and fwd_rsN!=0.
  - fwd_valN = value of the youngest matching entry (closest to tail); otherwise fwd_hitN=0 and fwd_valN=0.
  - The head entry being issued this cycle still counts as a hit.
- Pointers: wrap modulo DEPTH; count spans 0..DEPTH, width clog2(DEPTH)+1.

Optional Feature:
- Macro: RF_COMMIT_STATS_EN.
- Defined:
  - Adds outputs stat_commits (32) and stat_full_cycles (32).
  - stat_commits increments on each rf_valid pop; stat_full_cycles increments each rdy_in cycle with count==DEPTH && cm_valid.
  - Both counters wrap at 2^32 and are zeroed on reset.
- Undefined: the ports and counters are absent and all other behaviour is identical.

Decomposition:
- Shared constants header: REG_NUM_WIDTH, ROB_SIZE_WIDTH and the all-ones "no dependency" tag value.
- One sub-module, rf_commit_fifo: storage, pointers, count and stale bits.
- The parent module holds the handshake, flush gating and the youngest-match forwarding priority mux.

Test Plan:
- Reset, then commit rd=5 value=0xDEADBEEF tag=3 → rf_valid one cycle later with rd=5, value=0xDEADBEEF, tag=3; empty_out returns to 1.
- Hold rf issue via need_flush_in and push 4 commits → cm_ready=0 after the 4th; the 5th is not accepted until a pop.
- Buffer rd=7 values 1 then 2, stall with rdy_in=0, set fwd_rs1=7 → fwd_hit1=1, fwd_val1=2; fwd_rs2=0 → fwd_hit2=0.
- Two entries buffered, pulse need_flush_in one cycle → no rf_valid that cycle; the next two cycles write both entries with rf_tag=4'b1111.
- Commit with rd=0 → accepted, count stays 0, no rf_valid.
- Assert rst_in=0 with 3 entries buffered → next cycle empty_out=1, rf_valid=0, and no stale write appears afterwards.

Source files
------------

// File: rtl/rf_commit_sched_pkg.sv
// Shared widths, the "no dependency" tag and the buffered commit entry layout
// for the register-file commit scheduler.
package rf_commit_sched_pkg;

    localparam int unsigned REG_NUM_WIDTH  = 5;
    localparam int unsigned ROB_SIZE_WIDTH = 3;
    localparam int unsigned TAG_WIDTH      = ROB_SIZE_WIDTH + 1;
    localparam int unsigned VALUE_WIDTH    = 32;

    localparam logic [TAG_WIDTH-1:0] NO_DEP_TAG = '1;

    typedef struct packed {
        logic [REG_NUM_WIDTH-1:0] rd;
        logic [VALUE_WIDTH-1:0]   value;
        logic [TAG_WIDTH-1:0]     tag;
        logic                     stale;
    } cm_entry_t;

endpackage

// File: rtl/rf_commit_fifo.sv
// Commit buffer: entry storage, head/tail pointers, occupancy count and the
// per-entry stale bits set by a flush.
module rf_commit_fifo
    import rf_commit_sched_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  cm_entry_t              push_entry,
    output cm_entry_t [DEPTH-1:0]  slots,
    output logic [PTR_W-1:0]       head,
    output logic [CNT_W-1:0]       count
);

    logic [PTR_W-1:0] tail;

    // Flush marks every slot stale; a slot written in the same cycle takes
    // the stale bit carried by push_entry instead (last assignment wins).
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots[i].stale <= 1'b0;
            end
        end else begin
            if (flush) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    slots[i].stale <= 1'b1;
                end
            end
            if (push) begin
                slots[tail] <= push_entry;
                tail        <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rf_commit_sched.sv
// Commit-side RF write scheduler: ROB handshake, flush-gated issue and
// youngest-match decode forwarding. Optional counters via RF_COMMIT_STATS_EN.
module rf_commit_sched
    import rf_commit_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     need_flush_in,
    input  logic                     cm_valid,
    output logic                     cm_ready,
    input  logic [REG_NUM_WIDTH-1:0] cm_rd,
    input  logic [VALUE_WIDTH-1:0]   cm_value,
    input  logic [TAG_WIDTH-1:0]     cm_tag,
    output logic                     rf_valid,
    output logic [REG_NUM_WIDTH-1:0] rf_rd,
    output logic [VALUE_WIDTH-1:0]   rf_value,
    output logic [TAG_WIDTH-1:0]     rf_tag,
    input  logic [REG_NUM_WIDTH-1:0] fwd_rs1,
    input  logic [REG_NUM_WIDTH-1:0] fwd_rs2,
    output logic                     fwd_hit1,
    output logic [VALUE_WIDTH-1:0]   fwd_val1,
    output logic                     fwd_hit2,
    output logic [VALUE_WIDTH-1:0]   fwd_val2,
`ifdef RF_COMMIT_STATS_EN
    output logic [31:0]              stat_commits,
    output logic [31:0]              stat_full_cycles,
`endif
    output logic                     empty_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    cm_entry_t [DEPTH-1:0] slots;
    cm_entry_t             head_e;
    cm_entry_t             push_e;
    cm_entry_t             fwd_e;
    logic [PTR_W-1:0]      head;
    logic [CNT_W-1:0]      count;
    logic                  active;
    logic                  empty;
    logic                  push;
    logic                  flush;

    assign active   = rst_in && rdy_in;
    assign empty    = (count == '0);
    assign cm_ready = active && (count < CNT_W'(DEPTH));
    // x0 writes are acknowledged but never occupy a slot.
    assign push     = cm_valid && cm_ready && (cm_rd != '0);
    assign flush    = active && need_flush_in;
    assign rf_valid = active && !empty && !need_flush_in;

    assign push_e = '{rd: cm_rd, value: cm_value, tag: cm_tag, stale: flush};

    rf_commit_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .push       (push),
        .pop        (rf_valid),
        .flush      (flush),
        .push_entry (push_e),
        .slots      (slots),
        .head       (head),
        .count      (count)
    );

    // Stale entries must not clear a dependency the RF already released.
    assign head_e    = slots[head];
    assign rf_rd     = head_e.rd;
    assign rf_value  = head_e.value;
    assign rf_tag    = head_e.stale ? NO_DEP_TAG : head_e.tag;
    assign empty_out = !rst_in || empty;

    // Walk oldest to youngest so the last match (nearest tail) wins.
    always_comb begin
        fwd_hit1 = 1'b0;
        fwd_val1 = '0;
        fwd_hit2 = 1'b0;
        fwd_val2 = '0;
        fwd_e    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_e = slots[head + PTR_W'(i)];
            if (rst_in && (CNT_W'(i) < count)) begin
                if ((fwd_rs1 != '0) && (fwd_e.rd == fwd_rs1)) begin
                    fwd_hit1 = 1'b1;
                    fwd_val1 = fwd_e.value;
                end
                if ((fwd_rs2 != '0) && (fwd_e.rd == fwd_rs2)) begin
                    fwd_hit2 = 1'b1;
                    fwd_val2 = fwd_e.value;
                end
            end
        end
    end

`ifdef RF_COMMIT_STATS_EN
    // Pop and back-pressure counters, free-running modulo 2^32.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            stat_commits     <= '0;
            stat_full_cycles <= '0;
        end else begin
            if (rf_valid) begin
                stat_commits <= stat_commits + 32'(1);
            end
            if (rdy_in && (count == CNT_W'(DEPTH)) && cm_valid) begin
                stat_full_cycles <= stat_full_cycles + 32'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_rf_commit_sched.sv
// Bench for rf_commit_sched: directed vector table followed by random
// traffic checked against a queue-based reference model.
module tb_rf_commit_sched;
    import rf_commit_sched_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, need_flush_in, cm_valid, cm_ready;
    logic [4:0]  cm_rd, rf_rd, fwd_rs1, fwd_rs2;
    logic [31:0] cm_value, rf_value, fwd_val1, fwd_val2;
    logic [3:0]  cm_tag, rf_tag;
    logic        rf_valid, fwd_hit1, fwd_hit2, empty_out;

    int n_tests = 0;
    int n_fail  = 0;
    int row_id  = 0;

    always #5 clk_in = ~clk_in;

    rf_commit_sched #(.DEPTH(4)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .need_flush_in (need_flush_in),
        .cm_valid      (cm_valid),
        .cm_ready      (cm_ready),
        .cm_rd         (cm_rd),
        .cm_value      (cm_value),
        .cm_tag        (cm_tag),
        .rf_valid      (rf_valid),
        .rf_rd         (rf_rd),
        .rf_value      (rf_value),
        .rf_tag        (rf_tag),
        .fwd_rs1       (fwd_rs1),
        .fwd_rs2       (fwd_rs2),
        .fwd_hit1      (fwd_hit1),
        .fwd_val1      (fwd_val1),
        .fwd_hit2      (fwd_hit2),
        .fwd_val2      (fwd_val2),
        .empty_out     (empty_out)
    );

    typedef struct {
        bit          rst, rdy, fl, v;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [3:0]  tag;
        logic [4:0]  rs1, rs2;
        bit          e_ready, e_rfv;
        logic [4:0]  e_rd;
        logic [31:0] e_val;
        logic [3:0]  e_tag;
        bit          e_h1;
        logic [31:0] e_v1;
        bit          e_h2;
        logic [31:0] e_v2;
        bit          e_emp;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        logic [3:0]  tag;
        bit          stale;
    } m_ent_t;

    m_ent_t mq[$];
    vec_t   vecs[$];

    function automatic vec_t mk(input bit rst, input bit rdy, input bit fl, input bit v,
                                input logic [4:0] rd, input logic [31:0] val, input logic [3:0] tag,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input bit er, input bit erv, input logic [4:0] erd,
                                input logic [31:0] eval, input logic [3:0] etag,
                                input bit eh1, input logic [31:0] ev1,
                                input bit eh2, input logic [31:0] ev2, input bit eemp);
        vec_t r;
        r.rst = rst; r.rdy = rdy; r.fl = fl; r.v = v;
        r.rd = rd; r.val = val; r.tag = tag; r.rs1 = rs1; r.rs2 = rs2;
        r.e_ready = er; r.e_rfv = erv; r.e_rd = erd; r.e_val = eval; r.e_tag = etag;
        r.e_h1 = eh1; r.e_v1 = ev1; r.e_h2 = eh2; r.e_v2 = ev2; r.e_emp = eemp;
        return r;
    endfunction

    // Expected outputs from the retired-but-unwritten list held in mq.
    function automatic void model_expect(inout vec_t v);
        bit act;
        act       = v.rst && v.rdy;
        v.e_ready = act && (mq.size() < 4);
        v.e_rfv   = act && (mq.size() > 0) && !v.fl;
        v.e_rd    = '0; v.e_val = '0; v.e_tag = '0;
        if (v.e_rfv) begin
            v.e_rd  = mq[0].rd;
            v.e_val = mq[0].val;
            v.e_tag = mq[0].stale ? 4'hF : mq[0].tag;
        end
        v.e_h1 = 1'b0; v.e_v1 = '0; v.e_h2 = 1'b0; v.e_v2 = '0;
        if (v.rst) begin
            foreach (mq[i]) begin
                if (v.rs1 != 0 && mq[i].rd == v.rs1) begin v.e_h1 = 1'b1; v.e_v1 = mq[i].val; end
                if (v.rs2 != 0 && mq[i].rd == v.rs2) begin v.e_h2 = 1'b1; v.e_v2 = mq[i].val; end
            end
        end
        v.e_emp = !v.rst || (mq.size() == 0);
    endfunction

    function automatic void model_step(input vec_t v);
        bit can_push;
        m_ent_t e;
        if (!v.rst) begin
            mq.delete();
        end else if (v.rdy) begin
            can_push = (mq.size() < 4);
            if (v.fl) foreach (mq[i]) mq[i].stale = 1'b1;
            if (!v.fl && mq.size() > 0) void'(mq.pop_front());
            if (v.v && can_push && v.rd != 0) begin
                e.rd = v.rd; e.val = v.val; e.tag = v.tag; e.stale = v.fl;
                mq.push_back(e);
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, row_id, act, exp);
        end
    endtask

    task automatic run_row(input vec_t v);
        rst_in = v.rst; rdy_in = v.rdy; need_flush_in = v.fl; cm_valid = v.v;
        cm_rd = v.rd; cm_value = v.val; cm_tag = v.tag; fwd_rs1 = v.rs1; fwd_rs2 = v.rs2;
        @(negedge clk_in);
        chk("cm_ready",  32'(cm_ready),  32'(v.e_ready));
        chk("rf_valid",  32'(rf_valid),  32'(v.e_rfv));
        if (v.e_rfv) begin
            chk("rf_rd",    32'(rf_rd),    32'(v.e_rd));
            chk("rf_value", rf_value,      v.e_val);
            chk("rf_tag",   32'(rf_tag),   32'(v.e_tag));
        end
        chk("fwd_hit1",  32'(fwd_hit1),  32'(v.e_h1));
        chk("fwd_val1",  fwd_val1,       v.e_v1);
        chk("fwd_hit2",  32'(fwd_hit2),  32'(v.e_h2));
        chk("fwd_val2",  fwd_val2,       v.e_v2);
        chk("empty_out", 32'(empty_out), 32'(v.e_emp));
        @(posedge clk_in);
        model_step(v);
        #1;
        row_id++;
    endtask

    initial begin
        vec_t rv;
        rst_in = 1'b0; rdy_in = 1'b1; need_flush_in = 1'b0; cm_valid = 1'b0;
        cm_rd = '0; cm_value = '0; cm_tag = '0; fwd_rs1 = '0; fwd_rs2 = '0;
        @(posedge clk_in); #1;

        // rst rdy fl v | rd val tag | rs1 rs2 | ready rfv rd val tag | h1 v1 h2 v2 | empty
        vecs.push_back(mk(0,1,0,0, 0,0,0, 0,0, 0,0,0,0,0, 0,0,0,0,1));
        vecs.push_back(mk(1,1,0,1, 5,32'hDEADBEEF,3, 5,0, 1,0,0,0,0, 0,0,0,0,1));
        vecs.push_back(mk(1,1,0,0, 0,0,0, 5,0, 1,1,5,32'hDEADBEEF,3, 1,32'hDEADBEEF,0,0,0));
        vecs.push_back(mk(1,1,0,0, 0,0,0, 5,0, 1,0,0,0,0, 0,0,0,0,1));
        // fill under flush, fifth push refused while full
        vecs.push_back(mk(1,1,1,1, 1,32'h11,1, 0,0, 1,0,0,0,0, 0,0,0,0,1));
        vecs.push_back(mk(1,1,1,1, 2,32'h12,2, 0,0, 1,0,0,0,0, 0,0,0,0,0));
        vecs.push_back(mk(1,1,1,1, 3,32'h13,3, 0,0, 1,0,0,0,0, 0,0,0,0,0));
        vecs.push_back(mk(1,1,1,1, 4,32'h14,4, 0,0, 1,0,0,0,0, 0,0,0,0,0));
        vecs.push_back(mk(1,1,1,1, 5,32'h15,5, 2,4, 0,0,0,0,0, 1,32'h12,1,32'h14,0));
        vecs.push_back(mk(1,1,0,1, 5,32'h15,5, 0,0, 0,1,1,32'h11,4'hF, 0,0,0,0,0));
        vecs.push_back(mk(1,1,0,1, 5,32'h15,5, 0,0, 1,1,2,32'h12,4'hF, 0,0,0,0,0));
        vecs.push_back(mk(1,1,0,0, 0,0,0, 5,0, 1,1,3,32'h13,4'hF, 1,32'h15,0,0,0));
        vecs.push_back(mk(1,1,0,0, 0,0,0, 0,0, 1,1,4,32'h14,4'hF, 0,0,0,0,0));
        vecs.push_back(mk(1,1,0,0, 0,0,0, 0,0, 1,1,5,32'h15,5, 0,0,0,0,0));
        vecs.push_back(mk(1,1,0,0, 0,0,0, 0,0, 1,0,0,0,0, 0,0,0,0,1));
        // youngest-match forwarding across an rdy_in stall
        vecs.push_back(mk(1,1,1,1, 7,1,1, 7,0, 1,0,0,0,0, 0,0,0,0,1));
        vecs.push_back(mk(1,1,1,1, 7,2,2, 7,0, 1,0,0,0,0, 1,1,0,0,0));
        vecs.push_back(mk(1,0,0,0, 0,0,0, 7,0, 0,0,0,0,0, 1,2,0,0,0));
        vecs.push_back(mk(1,0,0,0, 0,0,0, 7,7, 0,0,0,0,0, 1,2,1,2,0));
        vecs.push_back(mk(1,1,0,0, 0,0,0, 7,0, 1,1,7,1,4'hF, 1,2,0,0,0));
        vecs.push_back(mk(1,1,0,0, 0,0,0, 7,0, 1,1,7,2,4'hF, 1,2,0,0,0));
        vecs.push_back(mk(1,1,0,0, 0,0,0, 7,0, 1,0,0,0,0, 0,0,0,0,1));
        // one-cycle flush with an enqueue in the same cycle
        vecs.push_back(mk(1,1,0,1, 8,32'h80,6, 0,0, 1,0,0,0,0, 0,0,0,0,1));
        vecs.push_back(mk(1,1,1,1, 9,32'h90,7, 8,9, 1,0,0,0,0, 1,32'h80,0,0,0));
        vecs.push_back(mk(1,1,0,0, 0,0,0, 8,9, 1,1,8,32'h80,4'hF, 1,32'h80,1,32'h90,0));
        vecs.push_back(mk(1,1,0,0, 0,0,0, 8,9, 1,1,9,32'h90,4'hF, 0,0,1,32'h90,0));
        vecs.push_back(mk(1,1,0,0, 0,0,0, 0,0, 1,0,0,0,0, 0,0,0,0,1));
        // x0 commit is acknowledged but discarded
        vecs.push_back(mk(1,1,0,1, 0,32'h55,2, 0,0, 1,0,0,0,0, 0,0,0,0,1));
        vecs.push_back(mk(1,1,0,0, 0,0,0, 0,0, 1,0,0,0,0, 0,0,0,0,1));
        // reset with three buffered entries
        vecs.push_back(mk(1,1,1,1, 10,32'hA0,0, 0,0, 1,0,0,0,0, 0,0,0,0,1));
        vecs.push_back(mk(1,1,1,1, 11,32'hA1,1, 0,0, 1,0,0,0,0, 0,0,0,0,0));
        vecs.push_back(mk(1,1,1,1, 12,32'hA2,2, 10,0, 1,0,0,0,0, 1,32'hA0,0,0,0));
        vecs.push_back(mk(0,1,0,0, 0,0,0, 10,0, 0,0,0,0,0, 0,0,0,0,1));
        vecs.push_back(mk(1,1,0,0, 0,0,0, 10,0, 1,0,0,0,0, 0,0,0,0,1));
        vecs.push_back(mk(1,1,0,0, 0,0,0, 10,0, 1,0,0,0,0, 0,0,0,0,1));

        foreach (vecs[i]) run_row(vecs[i]);

        for (int k = 0; k < 2000; k++) begin
            rv.rst = ($urandom_range(39) != 0);
            rv.rdy = ($urandom_range(7) != 0);
            rv.fl  = ($urandom_range(5) == 0);
            rv.v   = ($urandom_range(1) == 1);
            rv.rd  = 5'($urandom_range(7));
            rv.val = $urandom;
            rv.tag = 4'($urandom_range(15));
            rv.rs1 = 5'($urandom_range(7));
            rv.rs2 = 5'($urandom_range(7));
            model_expect(rv);
            run_row(rv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
